// File: rtl/QuplsPkg.sv
// Shared ROB and checkpoint types used by the checkpoint-release logic.
package QuplsPkg;

  localparam int ROB_ENTRIES    = 16;
  localparam int ROB_GROUP_SIZE = 4;
  localparam int NCHKPT         = 16;

  typedef logic [$clog2(NCHKPT)-1:0]                     checkpt_ndx_t;
  typedef logic [$clog2(ROB_ENTRIES/ROB_GROUP_SIZE)-1:0] rob_grp_ndx_t;

  typedef struct packed {
    logic br;
  } decbus_t;

  typedef struct packed {
    logic         v;
    logic [1:0]   done;
    decbus_t      decbus;
    checkpt_ndx_t cndx;
  } rob_entry_t;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/qupls_rel_queue.sv
// Circular FIFO accepting up to NPORT pushes and NPORT pops per cycle;
// pops beyond the current occupancy are ignored.
module qupls_rel_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int NPORT = 2,
  localparam int AW  = $clog2(DEPTH),
  localparam int CW  = AW + 1,
  localparam int PCW = $clog2(NPORT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PCW-1:0]   push_cnt,
  input  logic [WIDTH-1:0] push_data [NPORT],
  input  logic [PCW-1:0]   pop_cnt,
  output logic [WIDTH-1:0] rd_data [NPORT],
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    free_slots
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pop_eff;

  always_comb begin
    pop_eff = (CW'(pop_cnt) > count_q) ? count_q : CW'(pop_cnt);
    mem_d   = mem_q;
    for (int k = 0; k < NPORT; k++) begin
      if (k < int'(push_cnt)) mem_d[tail_q + AW'(k)] = push_data[k];
    end
    head_d  = head_q + AW'(pop_eff);
    tail_d  = tail_q + AW'(push_cnt);
    count_d = count_q - pop_eff + CW'(push_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NPORT; k++) rd_data[k] = mem_q[head_q + AW'(k)];
  end

  assign count      = count_q;
  assign free_slots = CW'(DEPTH) - count_q;

endmodule

// File: rtl/qupls_chkpt_release_unit.sv
// Finds completed ROB groups holding branches and queues their checkpoints
// for return to the allocator, oldest group first, once per allocation.
module qupls_chkpt_release_unit
  import QuplsPkg::*;
#(
  parameter int GROUP_SIZE = ROB_GROUP_SIZE,
  parameter int REL_PORTS  = 2,
  parameter int QDEPTH     = 8,
  localparam int NGRP = ROB_ENTRIES / GROUP_SIZE,
  localparam int GW   = $clog2(NGRP),
  localparam int CW   = $clog2(QDEPTH) + 1
) (
  input  logic           rst,
  input  logic           clk,
  input  rob_entry_t     rob [ROB_ENTRIES],
  input  logic [GW-1:0]  head_grp,
  input  logic           grp_alloc_v,
  input  logic [GW-1:0]  grp_alloc,
  input  logic           flush,
  input  logic           rel_rdy,
  output logic [REL_PORTS-1:0] rel_v,
  output checkpt_ndx_t   rel_chkpt [REL_PORTS],
  output logic           q_full,
  output logic [CW-1:0]  q_count
);

  localparam int CKW = $bits(checkpt_ndx_t);
  localparam int IW  = $clog2(ROB_ENTRIES);
  localparam int PCW = $clog2(REL_PORTS + 1);

  logic [NGRP-1:0] freed_q, freed_d;
  logic [NGRP-1:0] qual;
  logic [CKW-1:0]  push_data [REL_PORTS];
  logic [CKW-1:0]  rd_data [REL_PORTS];
  logic [PCW-1:0]  push_cnt, pop_cnt;
  logic [CW-1:0]   count, free_slots;

  // A group being reallocated this cycle never qualifies: allocation wins.
  always_comb begin
    logic all_done;
    logic any_br;
    for (int g = 0; g < NGRP; g++) begin
      all_done = 1'b1;
      any_br   = 1'b0;
      for (int e = 0; e < GROUP_SIZE; e++) begin
        all_done = all_done & ((&rob[IW'(g*GROUP_SIZE + e)].done) | ~rob[IW'(g*GROUP_SIZE + e)].v);
        any_br   = any_br | rob[IW'(g*GROUP_SIZE + e)].decbus.br;
      end
      qual[g] = all_done & any_br & ~freed_q[g] & ~flush
              & ~(grp_alloc_v && (grp_alloc == GW'(g)));
    end
  end

  always_comb begin
    logic [GW-1:0] g;
    logic [IW-1:0] nxt;
    int            n;
    int            lim;
    pop_cnt = '0;
    if (rel_rdy) pop_cnt = (count < CW'(REL_PORTS)) ? PCW'(count) : PCW'(REL_PORTS);
    lim     = imin(REL_PORTS, int'(free_slots) + int'(pop_cnt));
    n       = 0;
    freed_d = freed_q;
    g       = '0;
    nxt     = '0;
    for (int k = 0; k < REL_PORTS; k++) push_data[k] = '0;
    // Rotating scan from the head keeps the pushes in age order.
    for (int i = 0; i < NGRP; i++) begin
      g   = head_grp + GW'(i);
      nxt = IW'(((int'(g) + 1) * GROUP_SIZE) % ROB_ENTRIES);
      if (qual[g] && n < lim) begin
        for (int k = 0; k < REL_PORTS; k++) begin
          if (n == k) push_data[k] = rob[nxt].cndx;
        end
        freed_d[g] = 1'b1;
        n = n + 1;
      end
    end
    push_cnt = PCW'(n);
    if (grp_alloc_v) freed_d[grp_alloc] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) freed_q <= '0;
    else     freed_q <= freed_d;
  end

  qupls_rel_queue #(
    .WIDTH (CKW),
    .DEPTH (QDEPTH),
    .NPORT (REL_PORTS)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_cnt   (push_cnt),
    .push_data  (push_data),
    .pop_cnt    (pop_cnt),
    .rd_data    (rd_data),
    .count      (count),
    .free_slots (free_slots)
  );

  always_comb begin
    for (int k = 0; k < REL_PORTS; k++) begin
      rel_v[k]     = count > CW'(k);
      rel_chkpt[k] = rd_data[k];
    end
  end

  assign q_count = count;
  assign q_full  = free_slots < CW'(REL_PORTS);

endmodule

// File: tb/tb_qupls_chkpt_release_unit.sv
// Bench for the checkpoint-release unit: directed vector table, corner
// sequences, then random traffic against a queue-based reference model.
module tb_qupls_chkpt_release_unit;
  import QuplsPkg::*;

  localparam int RP = 2;
  localparam int QD = 8;
  localparam int GS = 4;
  localparam int NG = ROB_ENTRIES / GS;

  logic         clk = 1'b0;
  logic         rst;
  rob_entry_t   rob [ROB_ENTRIES];
  logic [1:0]   head_grp, grp_alloc;
  logic         grp_alloc_v, flush, rel_rdy;
  logic [RP-1:0] rel_v;
  checkpt_ndx_t rel_chkpt [RP];
  logic         q_full;
  logic [3:0]   q_count;

  qupls_chkpt_release_unit #(.GROUP_SIZE(GS), .REL_PORTS(RP), .QDEPTH(QD)) dut (
    .rst(rst), .clk(clk), .rob(rob), .head_grp(head_grp),
    .grp_alloc_v(grp_alloc_v), .grp_alloc(grp_alloc), .flush(flush),
    .rel_rdy(rel_rdy), .rel_v(rel_v), .rel_chkpt(rel_chkpt),
    .q_full(q_full), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  checkpt_ndx_t ck_tab [NG];
  checkpt_ndx_t mq [$];
  bit           mfreed [NG];

  typedef struct {
    logic [3:0] mask;
    int         head;
    bit         av;
    int         ag;
    bit         fl;
    bit         rdy;
    logic [1:0] ev;
    int         c0;
    int         c1;
    int         cnt;
  } vec_t;
  vec_t tab [15];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Groups in mask are complete with a branch in their second entry;
  // others are still in flight. Only group-start entries carry real cndx.
  task automatic set_rob(input logic [3:0] mask);
    for (int e = 0; e < ROB_ENTRIES; e++) begin
      rob[e].v         = 1'b1;
      rob[e].done      = mask[e/GS] ? 2'b11 : 2'b01;
      rob[e].decbus.br = (e % GS) == 1;
      rob[e].cndx      = (e % GS == 0) ? ck_tab[e/GS] : 4'hF;
    end
  endtask

  function automatic bit model_qual(input int g);
    bit all_ok = 1;
    bit has_br = 0;
    if (mfreed[g] || flush || (grp_alloc_v && int'(grp_alloc) == g)) return 0;
    for (int e = g*GS; e < (g+1)*GS; e++) begin
      if (rob[e].v && rob[e].done != 2'b11) all_ok = 0;
      if (rob[e].decbus.br) has_br = 1;
    end
    return all_ok && has_br;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int g = 0; g < NG; g++) mfreed[g] = 0;
  endtask

  task automatic model_step();
    int pops, lim, g;
    checkpt_ndx_t pushv [$];
    pops = rel_rdy ? ((mq.size() < RP) ? mq.size() : RP) : 0;
    lim  = QD - mq.size() + pops;
    if (lim > RP) lim = RP;
    for (int i = 0; i < NG; i++) begin
      g = (int'(head_grp) + i) % NG;
      if (pushv.size() < lim && model_qual(g)) begin
        pushv.push_back(rob[((g+1)*GS) % ROB_ENTRIES].cndx);
        mfreed[g] = 1;
      end
    end
    repeat (pops) void'(mq.pop_front());
    foreach (pushv[i]) mq.push_back(pushv[i]);
    if (grp_alloc_v) mfreed[grp_alloc] = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    check("rnd_count", int'(q_count), mq.size());
    check("rnd_full", int'(q_full), int'((QD - mq.size()) < RP));
    for (int k = 0; k < RP; k++) begin
      check("rnd_v", int'(rel_v[k]), int'(mq.size() > k));
      if (mq.size() > k) check("rnd_chkpt", int'(rel_chkpt[k]), int'(mq[k]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int exp_drain [10];
  int got_v [12];
  int got;

  initial begin
    ck_tab = '{4'd7, 4'd5, 4'd3, 4'd9};
    exp_drain = '{5, 3, 9, 7, 5, 3, 9, 7, 5, 3};
    rst = 1'b1;
    head_grp = '0; grp_alloc = '0; grp_alloc_v = 1'b0; flush = 1'b0; rel_rdy = 1'b0;
    set_rob(4'b0000);
    model_reset();

    //       mask    hd av ag fl rdy ev     c0 c1 cnt
    tab[0]  = '{4'b0000, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
    tab[1]  = '{4'b0010, 0, 0, 0, 0, 0, 2'b01, 3, 0, 1};
    tab[2]  = '{4'b0010, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0};
    tab[3]  = '{4'b0010, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0};
    tab[4]  = '{4'b0010, 0, 1, 1, 0, 1, 2'b00, 0, 0, 0};
    tab[5]  = '{4'b0010, 0, 0, 0, 0, 0, 2'b01, 3, 0, 1};
    tab[6]  = '{4'b0010, 0, 1, 1, 0, 1, 2'b00, 0, 0, 0};
    tab[7]  = '{4'b0010, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0};
    tab[8]  = '{4'b0010, 0, 0, 0, 0, 0, 2'b01, 3, 0, 1};
    tab[9]  = '{4'b0000, 0, 1, 1, 0, 1, 2'b00, 0, 0, 0};
    tab[10] = '{4'b0111, 2, 0, 0, 0, 0, 2'b11, 9, 5, 2};
    tab[11] = '{4'b0111, 2, 0, 0, 0, 0, 2'b11, 9, 5, 3};
    tab[12] = '{4'b0111, 2, 0, 0, 0, 1, 2'b01, 3, 0, 1};
    tab[13] = '{4'b1000, 0, 0, 0, 0, 1, 2'b01, 7, 0, 1};
    tab[14] = '{4'b0000, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0};

    #2;
    check("rst_v", int'(rel_v), 0);
    check("rst_count", int'(q_count), 0);
    check("rst_full", int'(q_full), 0);
    check("rst_chkpt0", int'(rel_chkpt[0]), 0);
    check("rst_chkpt1", int'(rel_chkpt[1]), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tab[i]) begin
      set_rob(tab[i].mask);
      head_grp    = 2'(tab[i].head);
      grp_alloc_v = tab[i].av;
      grp_alloc   = 2'(tab[i].ag);
      flush       = tab[i].fl;
      rel_rdy     = tab[i].rdy;
      step();
      check("tab_v", int'(rel_v), int'(tab[i].ev));
      check("tab_count", int'(q_count), tab[i].cnt);
      check("tab_full", int'(q_full), int'((QD - tab[i].cnt) < RP));
      if (tab[i].ev[0]) check("tab_chkpt0", int'(rel_chkpt[0]), tab[i].c0);
      if (tab[i].ev[1]) check("tab_chkpt1", int'(rel_chkpt[1]), tab[i].c1);
    end

    // One release per allocation even with the group held complete.
    set_rob(4'b0010); head_grp = 2'd0; flush = 1'b0; rel_rdy = 1'b1;
    grp_alloc_v = 1'b1; grp_alloc = 2'd1;
    step();
    check("hold_alloc_count", int'(q_count), 0);
    grp_alloc_v = 1'b0;
    step();
    check("hold_first_v", int'(rel_v), 1);
    check("hold_first_chkpt", int'(rel_chkpt[0]), 3);
    for (int c = 0; c < 20; c++) begin
      step();
      check("hold_no_repeat_v", int'(rel_v), 0);
      check("hold_no_repeat_count", int'(q_count), 0);
    end

    // Fill to capacity with rel_rdy low, then drain ten releases.
    do_reset();
    set_rob(4'b1111); head_grp = 2'd0; rel_rdy = 1'b0; grp_alloc_v = 1'b0;
    step();
    step();
    check("sat_fill4", int'(q_count), 4);
    for (int i = 0; i < 6; i++) begin
      grp_alloc_v = 1'b1;
      grp_alloc   = 2'(i % 4);
      step();
    end
    grp_alloc_v = 1'b0;
    step();
    step();
    check("sat_count", int'(q_count), 8);
    check("sat_full", int'(q_full), 1);
    check("sat_v", int'(rel_v), 3);
    rel_rdy = 1'b1;
    got = 0;
    for (int i = 0; i < 12; i++) got_v[i] = -1;
    for (int cyc = 0; cyc < 20 && got < 10; cyc++) begin
      for (int k = 0; k < RP; k++) begin
        if (rel_v[k] && got < 12) begin
          got_v[got] = int'(rel_chkpt[k]);
          got++;
        end
      end
      step();
    end
    check("drain_total", got, 10);
    for (int i = 0; i < 10; i++) check("drain_order", got_v[i], exp_drain[i]);
    check("drain_empty", int'(q_count), 0);

    // Reset mid-drain clears the outputs before the next edge.
    do_reset();
    set_rob(4'b0111); head_grp = 2'd0; rel_rdy = 1'b0;
    step();
    step();
    check("mid_pre_count", int'(q_count), 3);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("mid_rst_v", int'(rel_v), 0);
    check("mid_rst_count", int'(q_count), 0);
    check("mid_rst_full", int'(q_full), 0);
    check("mid_rst_chkpt0", int'(rel_chkpt[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int c = 0; c < 400; c++) begin
      for (int e = 0; e < ROB_ENTRIES; e++) begin
        rob[e].v         = $urandom_range(0, 3) != 0;
        rob[e].done      = ($urandom_range(0, 2) != 0) ? 2'b11 : 2'($urandom);
        rob[e].decbus.br = $urandom_range(0, 3) == 0;
        rob[e].cndx      = 4'($urandom);
      end
      head_grp    = 2'($urandom);
      grp_alloc_v = $urandom_range(0, 2) == 0;
      grp_alloc   = 2'($urandom);
      flush       = $urandom_range(0, 7) == 0;
      rel_rdy     = $urandom_range(0, 1) == 1;
      step();
      check_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
